mips_register_file: RTL and testbench

//  32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.

---
 rtl/mips_register_file_if.sv | 24 ++
 rtl/mips_register_file.sv | 63 ++++++
 tb/tb_mips_register_file.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_register_file_if.sv
// Register-file access bus: two combinational read ports and one write-back port.
// The datapath side holds the master modport; the register file holds the slave.
interface mips_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2
    );
endinterface

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file, $0 hardwired to zero, async active-low clear.
// Define RF_WRITE_BYPASS_EN to forward a same-cycle write onto the read ports.
module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_register_file_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  writeDec;
    logic [DATA_W-1:0] regFile_q [DEPTH];
    logic [DATA_W-1:0] regFile_d [DEPTH];

    // Gating by reg_write keeps an undriven write_reg from selecting anything.
    always_comb begin
        writeDec = '0;
        if (rf.reg_write) begin
            writeDec[rf.write_reg] = 1'b1;
        end
        writeDec[0] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regFile_d[i] = writeDec[i] ? rf.write_data : regFile_q[i];
        end
        regFile_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_q[i] <= regFile_d[i];
            end
        end
    end

    // Forwarding is suppressed while reset is held so both ports read zero.
    always_comb begin
        rf.read_data1 = (rf.read_reg1 == '0) ? '0 : regFile_q[rf.read_reg1];
`ifdef RF_WRITE_BYPASS_EN
        if (rst_n && rf.read_reg1 != '0 && writeDec[rf.read_reg1]) begin
            rf.read_data1 = rf.write_data;
        end
`endif
    end

    always_comb begin
        rf.read_data2 = (rf.read_reg2 == '0) ? '0 : regFile_q[rf.read_reg2];
`ifdef RF_WRITE_BYPASS_EN
        if (rst_n && rf.read_reg2 != '0 && writeDec[rf.read_reg2]) begin
            rf.read_data2 = rf.write_data;
        end
`endif
    end
endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: directed scenarios then random traffic,
// expected reads computed from an array model of the architectural registers.
module tb_mips_register_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mips_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rfIf ();

    mips_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rfIf)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } expT;

    expT         expQ[$];
    logic [31:0] model [32];
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] expRead(input int idx, input bit we, input int wr,
                                            input logic [31:0] wd, input bit inReset);
        if (inReset || idx == 0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
        if (we && wr != 0 && wr == idx) return wd;
`endif
        return model[idx];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input string port,
                               input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", tag, port, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the pre-edge read expectation goes to the scoreboard.
    task automatic applyStimulus(input string tag, input int rr1, input int rr2,
                                 input bit we, input int wr, input logic [31:0] wd,
                                 input bit rstLevel, input bit midRst);
        expT e;
        @(posedge clk);
        #1;
        rst_n              = rstLevel;
        rfIf.read_reg1     = ADDR_W'(rr1);
        rfIf.read_reg2     = ADDR_W'(rr2);
        rfIf.reg_write     = we;
        rfIf.write_reg     = ADDR_W'(wr);
        rfIf.write_data    = wd;
        if (!rstLevel) clearModel();
        if (midRst) begin
            #3;
            rst_n = 1'b0;
            clearModel();
        end
        e.tag  = tag;
        e.exp1 = expRead(rr1, we, wr, wd, !rst_n);
        e.exp2 = expRead(rr2, we, wr, wd, !rst_n);
        expQ.push_back(e);
        if (rst_n && we && wr != 0) model[wr] = wd;
    endtask

    // Monitor: the read ports are valid every cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                expT e;
                e = expQ.pop_front();
                checkOutput(e.tag, "rd1", rfIf.read_data1, e.exp1);
                checkOutput(e.tag, "rd2", rfIf.read_data2, e.exp2);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rr1, rr2, wr;
        bit we, rl, mr;
        logic [31:0] wd;
        clearModel();
        rfIf.read_reg1  = '0;
        rfIf.read_reg2  = '0;
        rfIf.reg_write  = 1'b0;
        rfIf.write_reg  = '0;
        rfIf.write_data = '0;

        applyStimulus("rst0",    0, 31, 0, 0, 32'h0, 0, 0);
        applyStimulus("t1w5",    5, 31, 1, 5, 32'hDEADBEEF, 1, 0);
        applyStimulus("t1pre",   5, 31, 0, 0, 32'h0, 1, 0);
        applyStimulus("t1hold",  5, 31, 0, 0, 32'h0, 0, 0);
        applyStimulus("t1rel",   5, 31, 0, 0, 32'h0, 1, 0);

        applyStimulus("t2w8",    8, 9, 1, 8, 32'h0000_00F0, 1, 0);
        applyStimulus("t2w9",    8, 9, 1, 9, 32'h0F0F_0F0F, 1, 0);
        applyStimulus("t2rd",    8, 9, 0, 0, 32'h0, 1, 0);
        applyStimulus("t2same",  9, 9, 0, 0, 32'h0, 1, 0);

        applyStimulus("t3w0",    0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
        applyStimulus("t3rd",    0, 8, 0, 0, 32'h0, 1, 0);

        applyStimulus("t4w12",  12, 12, 1, 12, 32'hAAAA_5555, 1, 0);
        applyStimulus("t4gate", 12, 12, 0, 12, 32'h1234_5678, 1, 0);
        applyStimulus("t4rd",   12, 12, 0, 12, 32'h1234_5678, 1, 0);

        applyStimulus("t5w3",    3, 0, 1, 3, 32'h1, 1, 0);
        applyStimulus("t5haz",   3, 0, 1, 3, 32'h2, 1, 0);
        applyStimulus("t5post",  3, 3, 0, 0, 32'h0, 1, 0);

        applyStimulus("t6w20",  20, 20, 1, 20, 32'h7, 1, 0);
        applyStimulus("t6chk",  20, 20, 0, 0, 32'h0, 1, 0);
        applyStimulus("t6mid",  20, 20, 1, 20, 32'h99, 1, 1);
        applyStimulus("t6held", 20, 20, 1, 20, 32'h99, 0, 0);
        applyStimulus("t6rel",  20, 20, 0, 0, 32'h0, 1, 0);

        // Small index pool most of the time so hazards and repeats are common.
        for (int n = 0; n < 400; n++) begin
            rr1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            rr2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            wr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            we  = ($urandom_range(0, 3) != 0);
            wd  = $urandom;
            rl  = ($urandom_range(0, 99) != 0);
            mr  = rl && ($urandom_range(0, 99) == 0);
            applyStimulus("rand", rr1, rr2, we, wr, wd, rl, mr);
        end

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
